// File: rtl/mem_access_ctrl_pkg.sv
// Shared types and helpers for the load/store sequencer: state encoding,
// default opcodes, strobe bundle and the one-hot register select helper.
package mem_access_pkg;

   typedef enum logic [3:0] {
      S_IDLE,
      S_ADDR,
      S_MAR,
      S_SDATA,
      S_SWR,
      S_SMEM,
      S_LMEM,
      S_LRD,
      S_LOUT,
      S_LWB,
      S_DONE,
      S_FAULT
   } state_e;

   localparam logic [3:0] OP_LOAD_DEF  = 4'b0010;
   localparam logic [3:0] OP_STORE_DEF = 4'b0011;
   localparam int         MAX_REGS     = 32;

   typedef struct packed {
      logic pc_inc;
      logic mar_in;
      logic mdr_write_en;
      logic mdr_read_en;
      logic mdr_out;
      logic mem_en;
      logic rw;
   } strobe_t;

   // Out-of-range indices select nothing rather than wrapping onto a real register.
   function automatic logic [MAX_REGS-1:0] onehot(input int idx, input int n);
      logic [MAX_REGS-1:0] v;
      v = '0;
      if (idx >= 0 && idx < n && idx < MAX_REGS) v = MAX_REGS'(1) << idx;
      return v;
   endfunction

endpackage

// File: rtl/mem_access_ctrl_if.sv
// Bus between the control unit / memory side (master) and the sequencer (slave).
interface mem_access_ctrl_if #(
   parameter int NREGS = 5
);
   logic             start;
   logic [15:0]      instruction;
   logic             mfc;
   logic             busy;
   logic             done;
   logic             err;
   logic             pc_inc;
   logic             mar_in;
   logic             mdr_write_en;
   logic             mdr_read_en;
   logic             mdr_out;
   logic             mem_en;
   logic             rw;
   logic [NREGS-1:0] rx_out;
   logic [NREGS-1:0] rx_in;

   modport master (
      output start, instruction, mfc,
      input  busy, done, err, pc_inc, mar_in, mdr_write_en, mdr_read_en,
             mdr_out, mem_en, rw, rx_out, rx_in
   );

   modport slave (
      input  start, instruction, mfc,
      output busy, done, err, pc_inc, mar_in, mdr_write_en, mdr_read_en,
             mdr_out, mem_en, rw, rx_out, rx_in
   );
endinterface

// File: rtl/mem_access_ctrl_watchdog.sv
// Counts mfc-low wait cycles; expired flags the tick that brings the count to TIMEOUT.
module mfc_watchdog #(
   parameter int TIMEOUT = 15
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic tick,
   output logic expired
);
   localparam int CW = $clog2(TIMEOUT + 1);

   logic [CW-1:0] count_q, count_d;

   always_comb begin
      count_d = count_q;
      if (clr)       count_d = '0;
      else if (tick) count_d = count_q + 1'b1;
   end

   assign expired = tick && (count_q == CW'(TIMEOUT - 1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) count_q <= '0;
      else     count_q <= count_d;
   end
endmodule

// File: rtl/mem_access_ctrl.sv
// Load/store sequencer: latches a memory instruction, walks the PC/MAR/MDR/register
// strobe sequence and finishes with done, or done+err on bad index or mfc timeout.
module mem_access_ctrl
   import mem_access_pkg::*;
#(
   parameter int         NREGS    = 5,
   parameter int         FIELD_W  = 6,
   parameter logic [3:0] OP_LOAD  = OP_LOAD_DEF,
   parameter logic [3:0] OP_STORE = OP_STORE_DEF,
   parameter int         TIMEOUT  = 15
) (
   input logic              clk,
   input logic              rst,
   mem_access_ctrl_if.slave bus
);
   state_e             state_q, state_d;
   logic [3:0]         opcode_q, opcode_d;
   logic [FIELD_W-1:0] p1_q, p1_d, p2_q, p2_d;
   strobe_t            strb_q, strb_d;
   logic               busy_q, busy_d, done_q, done_d, err_q, err_d;
   logic [NREGS-1:0]   rx_out_q, rx_out_d, rx_in_q, rx_in_d;

   logic [3:0]         op_in;
   logic [FIELD_W-1:0] p1_in, p2_in;
   logic               accept, illegal_in, in_wait, tick, clr, expired;

   assign op_in      = bus.instruction[15:12];
   assign p1_in      = bus.instruction[2*FIELD_W-1:FIELD_W];
   assign p2_in      = bus.instruction[FIELD_W-1:0];
   assign accept     = (state_q == S_IDLE) && bus.start &&
                       (op_in == OP_LOAD || op_in == OP_STORE);
   assign illegal_in = (int'(p1_in) >= NREGS) || (int'(p2_in) >= NREGS);
   assign in_wait    = (state_q == S_SMEM) || (state_q == S_LMEM);
   assign tick       = in_wait && !bus.mfc;
   assign clr        = !in_wait && (state_d == S_SMEM || state_d == S_LMEM);

   mfc_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
      .clk     (clk),
      .rst     (rst),
      .clr     (clr),
      .tick    (tick),
      .expired (expired)
   );

   // NOTE: every _d gets a default before the case, so no path leaves it unassigned
   // and no latch is inferred.
   always_comb begin
      state_d  = state_q;
      opcode_d = opcode_q;
      p1_d     = p1_q;
      p2_d     = p2_q;
      case (state_q)
         S_IDLE: if (accept) begin
            opcode_d = op_in;
            p1_d     = p1_in;
            p2_d     = p2_in;
            state_d  = illegal_in ? S_FAULT : S_ADDR;
         end
         S_ADDR:  state_d = S_MAR;
         S_MAR:   state_d = (opcode_q == OP_STORE) ? S_SDATA : S_LMEM;
         S_SDATA: state_d = S_SWR;
         S_SWR:   state_d = S_SMEM;
         S_SMEM:  if (bus.mfc) state_d = S_DONE; else if (expired) state_d = S_FAULT;
         S_LMEM:  if (bus.mfc) state_d = S_LRD;  else if (expired) state_d = S_FAULT;
         S_LRD:   state_d = S_LOUT;
         S_LOUT:  state_d = S_LWB;
         S_LWB:   state_d = S_DONE;
         default: state_d = S_IDLE;
      endcase
   end

   // Outputs are decoded from the next state and next fields and then registered,
   // so the pins are a clean Moore function of the flopped state.
   always_comb begin
      strb_d   = '0;
      rx_out_d = '0;
      rx_in_d  = '0;
      busy_d   = (state_d != S_IDLE);
      done_d   = (state_d == S_DONE) || (state_d == S_FAULT);
      err_d    = (state_d == S_FAULT);
      case (state_d)
         S_ADDR:  begin strb_d.pc_inc = 1'b1; rx_out_d = NREGS'(onehot(int'(p2_d), NREGS)); end
         S_MAR:   begin strb_d.mar_in = 1'b1; rx_out_d = NREGS'(onehot(int'(p2_d), NREGS)); end
         S_SDATA: rx_out_d = NREGS'(onehot(int'(p1_d), NREGS));
         S_SWR:   begin strb_d.mdr_write_en = 1'b1; rx_out_d = NREGS'(onehot(int'(p1_d), NREGS)); end
         S_SMEM:  strb_d.mem_en = 1'b1;
         S_LMEM:  begin strb_d.mem_en = 1'b1; strb_d.rw = 1'b1; end
         S_LRD:   begin strb_d.mem_en = 1'b1; strb_d.rw = 1'b1; strb_d.mdr_read_en = 1'b1; end
         S_LOUT:  begin strb_d.mdr_out = 1'b1; strb_d.rw = 1'b1; end
         S_LWB:   begin
            strb_d.mdr_out = 1'b1;
            strb_d.rw      = 1'b1;
            rx_in_d        = NREGS'(onehot(int'(p1_d), NREGS));
         end
         default: ;
      endcase
   end

   // NOTE: sequential state uses <= so every flop samples the pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= S_IDLE;
         opcode_q <= '0;
         p1_q     <= '0;
         p2_q     <= '0;
         strb_q   <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         err_q    <= 1'b0;
         rx_out_q <= '0;
         rx_in_q  <= '0;
      end else begin
         state_q  <= state_d;
         opcode_q <= opcode_d;
         p1_q     <= p1_d;
         p2_q     <= p2_d;
         strb_q   <= strb_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         err_q    <= err_d;
         rx_out_q <= rx_out_d;
         rx_in_q  <= rx_in_d;
      end
   end

   assign bus.busy         = busy_q;
   assign bus.done         = done_q;
   assign bus.err          = err_q;
   assign bus.pc_inc       = strb_q.pc_inc;
   assign bus.mar_in       = strb_q.mar_in;
   assign bus.mdr_write_en = strb_q.mdr_write_en;
   assign bus.mdr_read_en  = strb_q.mdr_read_en;
   assign bus.mdr_out      = strb_q.mdr_out;
   assign bus.mem_en       = strb_q.mem_en;
   assign bus.rw           = strb_q.rw;
   assign bus.rx_out       = rx_out_q;
   assign bus.rx_in        = rx_in_q;
endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: table vectors, reset/NREGS=8 corner sequences and
// random transactions checked cycle by cycle against a sequence-level model.
module tb_mem_access_ctrl;
   localparam int NR = 5;
   localparam int TO = 4;

   typedef struct packed {
      logic          busy, done, err;
      logic          pc_inc, mar_in, mdr_we, mdr_re, mdr_out, mem_en, rw;
      logic [NR-1:0] rx_out, rx_in;
   } obs_t;

   typedef struct {
      logic [15:0] instr;
      int          delay;
      int          exp_len;
      logic        exp_err;
   } vec_t;

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   n_checks = 0;
   int   n_fail   = 0;
   obs_t exp_q[$];
   int   mfc_q[$];  // 0 = drive low, 1 = drive high, 2 = don't care (random)

   always #5 clk = ~clk;

   mem_access_ctrl_if #(.NREGS(NR)) if0 ();
   mem_access_ctrl_if #(.NREGS(8))  if1 ();

   mem_access_ctrl #(.NREGS(NR), .TIMEOUT(TO)) dut0 (.clk(clk), .rst(rst), .bus(if0));
   mem_access_ctrl #(.NREGS(8))                dut1 (.clk(clk), .rst(rst), .bus(if1));

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
      end
   endtask

   function automatic obs_t sample0();
      obs_t o;
      o.busy    = if0.busy;         o.done   = if0.done;        o.err    = if0.err;
      o.pc_inc  = if0.pc_inc;       o.mar_in = if0.mar_in;
      o.mdr_we  = if0.mdr_write_en; o.mdr_re = if0.mdr_read_en;
      o.mdr_out = if0.mdr_out;      o.mem_en = if0.mem_en;      o.rw     = if0.rw;
      o.rx_out  = if0.rx_out;       o.rx_in  = if0.rx_in;
      return o;
   endfunction

   function automatic logic [NR-1:0] sel(input int i);
      return NR'(1 << i);
   endfunction

   function automatic obs_t step(input bit pc, mar, we, re, mo, me, rw,
                                 input logic [NR-1:0] ro, ri);
      obs_t o;
      o = '0;
      o.busy = 1'b1; o.pc_inc = pc; o.mar_in = mar; o.mdr_we = we; o.mdr_re = re;
      o.mdr_out = mo; o.mem_en = me; o.rw = rw; o.rx_out = ro; o.rx_in = ri;
      return o;
   endfunction

   function automatic obs_t finish_step(input bit is_err);
      obs_t o;
      o = '0;
      o.busy = 1'b1; o.done = 1'b1; o.err = is_err;
      return o;
   endfunction

   // Expected output per cycle after start is accepted, from the phase list of each
   // operation; delay = number of mfc-low wait cycles before mfc rises.
   task automatic build_model(input logic [15:0] instr, input int delay);
      logic [3:0] op;
      int         p1, p2, waits;
      bit         is_load;
      exp_q.delete();
      mfc_q.delete();
      op = instr[15:12];
      p1 = int'(instr[11:6]);
      p2 = int'(instr[5:0]);
      if (op != 4'h2 && op != 4'h3) return;
      if (p1 >= NR || p2 >= NR) begin
         exp_q.push_back(finish_step(1'b1)); mfc_q.push_back(2);
         return;
      end
      is_load = (op == 4'h2);
      exp_q.push_back(step(1,0,0,0,0,0,0, sel(p2), '0)); mfc_q.push_back(2);
      exp_q.push_back(step(0,1,0,0,0,0,0, sel(p2), '0)); mfc_q.push_back(2);
      if (!is_load) begin
         exp_q.push_back(step(0,0,0,0,0,0,0, sel(p1), '0)); mfc_q.push_back(2);
         exp_q.push_back(step(0,0,1,0,0,0,0, sel(p1), '0)); mfc_q.push_back(2);
      end
      waits = (delay < TO) ? delay + 1 : TO;
      for (int j = 0; j < waits; j++) begin
         exp_q.push_back(step(0,0,0,0,0,1,is_load, '0, '0));
         mfc_q.push_back((j == delay) ? 1 : 0);
      end
      if (delay >= TO) begin
         exp_q.push_back(finish_step(1'b1)); mfc_q.push_back(2);
         return;
      end
      if (is_load) begin
         exp_q.push_back(step(0,0,0,1,0,1,1, '0, '0));     mfc_q.push_back(2);
         exp_q.push_back(step(0,0,0,0,1,0,1, '0, '0));     mfc_q.push_back(2);
         exp_q.push_back(step(0,0,0,0,1,0,1, '0, sel(p1))); mfc_q.push_back(2);
      end
      exp_q.push_back(finish_step(1'b0)); mfc_q.push_back(2);
   endtask

   // Starts in an IDLE cycle, ends in the IDLE cycle after done. start and instruction
   // are scrambled while busy; they must be ignored.
   task automatic run_txn(input logic [15:0] instr, input int delay,
                          output int got_len, output logic got_err);
      obs_t o;
      build_model(instr, delay);
      got_len = 0;
      got_err = 1'b0;
      if0.start = 1'b1; if0.instruction = instr; if0.mfc = 1'($urandom);
      @(posedge clk); #1;
      for (int i = 0; i < exp_q.size(); i++) begin
         o = sample0();
         check($sformatf("instr %h cycle %0d", instr, i + 1), {12'b0, o}, {12'b0, exp_q[i]});
         if (o.done && got_len == 0) begin got_len = i + 1; got_err = o.err; end
         if0.mfc         = (mfc_q[i] == 2) ? 1'($urandom) : (mfc_q[i] == 1);
         if0.start       = 1'($urandom);
         if0.instruction = 16'($urandom);
         @(posedge clk); #1;
      end
      check($sformatf("instr %h idle after", instr), {12'b0, sample0()}, 32'h0);
      if0.start = 1'b0;
   endtask

   initial begin
      vec_t        vecs[10];
      int          len, done_at;
      logic        e;
      logic [7:0]  rx_in_seen;
      logic [3:0]  op;

      vecs[0] = '{16'h3042, 0, 6,  1'b0};  // store p1=1 p2=2, mfc at first SMEM cycle
      vecs[1] = '{16'h2103, 3, 10, 1'b0};  // load p1=4 p2=3, mfc on last allowed wait
      vecs[2] = '{16'h2005, 0, 1,  1'b1};  // param2 out of range
      vecs[3] = '{16'h2103, 4, 7,  1'b1};  // load timeout
      vecs[4] = '{16'h3042, 4, 9,  1'b1};  // store timeout
      vecs[5] = '{16'h3042, 2, 8,  1'b0};
      vecs[6] = '{16'h1042, 0, 0,  1'b0};  // non-memory opcode
      vecs[7] = '{16'h2140, 0, 1,  1'b1};  // param1 out of range
      vecs[8] = '{16'h2000, 0, 7,  1'b0};
      vecs[9] = '{16'h3104, 1, 7,  1'b0};

      if0.start = 1'b0; if0.instruction = '0; if0.mfc = 1'b0;
      if1.start = 1'b0; if1.instruction = '0; if1.mfc = 1'b0;
      #1 rst = 1'b1;
      #1;
      check("reset outputs", {12'b0, sample0()}, 32'h0);
      check("reset outputs n8", {29'b0, if1.busy, if1.done, if1.mem_en}, 32'h0);
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      check("idle after reset", {12'b0, sample0()}, 32'h0);

      for (int i = 0; i < 10; i++) begin
         run_txn(vecs[i].instr, vecs[i].delay, len, e);
         check($sformatf("vec%0d done cycle", i), len, vecs[i].exp_len);
         check($sformatf("vec%0d err", i), {31'b0, e}, {31'b0, vecs[i].exp_err});
      end

      // Reset in the middle of a store wait state.
      if0.start = 1'b1; if0.instruction = 16'h3042; if0.mfc = 1'b0;
      @(posedge clk); #1;
      if0.start = 1'b0;
      repeat (4) begin @(posedge clk); #1; end
      check("mem_en before reset", {31'b0, if0.mem_en}, 32'h1);
      #2 rst = 1'b1;
      #1;
      check("async reset mid access", {12'b0, sample0()}, 32'h0);
      @(posedge clk); #1;
      rst = 1'b0;
      check("idle after mid reset", {12'b0, sample0()}, 32'h0);
      run_txn(16'h3042, 0, len, e);
      check("store after reset len", len, 6);
      check("store after reset err", {31'b0, e}, 32'h0);

      // Random transactions.
      for (int n = 0; n < 40; n++) begin
         int r, p1, p2, d;
         r  = $urandom_range(0, 9);
         op = (r < 4) ? 4'h2 : (r < 8) ? 4'h3 : 4'($urandom_range(4, 15));
         p1 = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 63) : $urandom_range(0, NR - 1);
         p2 = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 63) : $urandom_range(0, NR - 1);
         d  = $urandom_range(0, TO + 1);
         run_txn({op, 6'(p1), 6'(p2)}, d, len, e);
      end

      // NREGS=8 instance: load p1=6 p2=7 with mfc held high.
      if1.start = 1'b1; if1.instruction = 16'h2187; if1.mfc = 1'b1;
      @(posedge clk); #1;
      check("n8 rx_out addr", {24'b0, if1.rx_out}, 32'h80);
      if1.start = 1'b0; if1.instruction = '0;
      done_at = 0;
      rx_in_seen = '0;
      for (int c = 1; c <= 20 && done_at == 0; c++) begin
         if (if1.rx_in != '0) rx_in_seen = if1.rx_in;
         if (if1.done) done_at = c;
         else begin @(posedge clk); #1; end
      end
      check("n8 done cycle", done_at, 7);
      check("n8 err", {31'b0, if1.err}, 32'h0);
      check("n8 rx_in", {24'b0, rx_in_seen}, 32'h40);
      @(posedge clk); #1;
      check("n8 idle", {31'b0, if1.busy}, 32'h0);
      if1.start = 1'b1; if1.instruction = 16'h2008;
      @(posedge clk); #1;
      if1.start = 1'b0;
      check("n8 illegal fault", {29'b0, if1.done, if1.err, if1.mem_en}, 32'h6);
      @(posedge clk); #1;
      check("n8 idle after fault", {30'b0, if1.busy, if1.done}, 32'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
